reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 198 +++++++++++++++++++
 tb/tb_reg_dump_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
//
// Walks a register file from index 0 up to LAST_REG and streams each word out
// over a valid/ready interface. One word is fetched per FETCH cycle (the
// register file read is combinational), and then it is held in SEND until
// downstream accepts it. At most one word is sent every two cycles.
//
// Optional feature (macro REG_DUMP_CHECKSUM_EN):
//   When defined, a running XOR of every dumped word is kept. After the
//   LAST_REG word is accepted, one extra word carrying that XOR is sent with
//   out_last=1. When undefined, the LAST_REG word itself carries out_last=1.
//
// Parameters:
//   LAST_REG       highest register index scanned (1..31)
//
// Ports:
//   clk            rising-edge clock, shared with the register file
//   rst            asynchronous active-high reset
//   start          dump request, sampled only in IDLE
//   Read_register  read address to the register file (0 while idle)
//   Read_data      combinational read data for Read_register
//   out_data       dumped word (registered)
//   out_valid      out_data holds a valid word
//   out_ready      downstream accepts out_data this cycle
//   out_last       current word is the final word of the dump
//   busy           dump in progress (any state other than IDLE)
//   done           one-cycle pulse after the final word is accepted
//
// States:
//   IDLE  | waiting for start, address parked at 0
//   FETCH | register at addr (or the checksum) captured into out_data
//   SEND  | word held valid until out_ready
//   DONE  | done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module reg_dump_reader #(
    parameter int LAST_REG = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  Read_register,
    input  logic [31:0] Read_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_ADDR = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [4:0]  addr, addr_n;
    logic [31:0] data_n;
    logic        valid_n;
    logic        last_n;
    logic        busy_n;
    logic        done_n;
    logic        accept;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0] csum, csum_n;
    // Set once the last register word has been accepted: the next FETCH
    // loads the checksum instead of register data.
    logic        csum_phase, csum_phase_n;
`endif

    assign accept        = out_valid && out_ready;
    assign Read_register = addr;

    always_comb begin
        state_n = state;
        addr_n  = addr;
        data_n  = out_data;
        valid_n = out_valid;
        last_n  = out_last;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_n       = csum;
        csum_phase_n = csum_phase;
`endif

        case (state)
            IDLE: begin
                addr_n = 5'd0;
                if (start) begin
                    state_n = FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_n       = 32'd0;
                    csum_phase_n = 1'b0;
`endif
                end
            end

            FETCH: begin
                state_n = SEND;
                valid_n = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                if (csum_phase) begin
                    data_n = csum;
                    last_n = 1'b1;
                end else begin
                    data_n = Read_data;
                    csum_n = csum ^ Read_data;
                    last_n = 1'b0;
                end
`else
                data_n = Read_data;
                last_n = (addr == LAST_ADDR);
`endif
            end

            SEND: begin
                if (accept) begin
                    valid_n = 1'b0;
                    last_n  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
                    if (csum_phase) begin
                        state_n = DONE;
                    end else if (addr == LAST_ADDR) begin
                        // Address stays at LAST_REG; only the source changes.
                        csum_phase_n = 1'b1;
                        state_n      = FETCH;
                    end else begin
                        addr_n  = addr + 5'd1;
                        state_n = FETCH;
                    end
`else
                    if (addr == LAST_ADDR) begin
                        state_n = DONE;
                    end else begin
                        addr_n  = addr + 5'd1;
                        state_n = FETCH;
                    end
`endif
                end
            end

            DONE: begin
                state_n = IDLE;
                addr_n  = 5'd0;
            end

            default: begin
                state_n = IDLE;
                addr_n  = 5'd0;
                valid_n = 1'b0;
                last_n  = 1'b0;
            end
        endcase

        // busy and done are registered copies of the next-state decode so
        // they line up exactly with the state they describe.
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= 5'd0;
            out_data  <= 32'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum       <= 32'd0;
            csum_phase <= 1'b0;
        end else begin
            csum       <= csum_n;
            csum_phase <= csum_phase_n;
        end
    end
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // main instance, LAST_REG = 31
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  rr;
    logic [31:0] rd, od;
    logic        ov, ol, bz, dn;
    logic [31:0] regs [32];

    // small instance, LAST_REG = 3, with a writable register file
    logic        start3 = 1'b0;
    logic        ready3 = 1'b0;
    logic [4:0]  rr3;
    logic [31:0] rd3, od3;
    logic        ov3, ol3, bz3, dn3;
    logic [31:0] regs3 [32];
    logic        wr3 = 1'b0;
    logic [4:0]  wa3 = 5'd0;
    logic [31:0] wd3 = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rd  = regs[rr];
    assign rd3 = regs3[rr3];

    always @(posedge clk) begin
        if (wr3) regs3[wa3] <= wd3;
    end

    reg_dump_reader u_dut (
        .clk(clk), .rst(rst), .start(start),
        .Read_register(rr), .Read_data(rd),
        .out_data(od), .out_valid(ov), .out_ready(out_ready),
        .out_last(ol), .busy(bz), .done(dn)
    );

    reg_dump_reader #(.LAST_REG(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .Read_register(rr3), .Read_data(rd3),
        .out_data(od3), .out_valid(ov3), .out_ready(ready3),
        .out_last(ol3), .busy(bz3), .done(dn3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected stream: registers 0..31 in order, plus their XOR when enabled.
    task automatic make_exp(output logic [31:0] q[$]);
        logic [31:0] x;
        x = 32'd0;
        q = {};
        for (int i = 0; i < 32; i++) begin
            q.push_back(regs[i]);
            x = x ^ regs[i];
        end
        if (CSUM) q.push_back(x);
    endtask

    // Runs one dump of the main instance; the start edge has just been
    // presented. mode 0: ready always, 1: ready 1,0,0,1, 2: random ready
    // and random start noise while busy.
    task automatic collect(input int mode, input bit hold);
        logic [31:0] exp[$];
        int          idx;
        int          cyc;
        bit          got_done;
        bit          stall;
        logic [31:0] sd;
        logic        sl;
        make_exp(exp);
        idx = 0; cyc = 0; got_done = 0; stall = 0; sd = 32'd0; sl = 1'b0;
        while (!got_done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (stall) begin
                chk("stall_valid", 32'(ov), 32'd1);
                chk("stall_data", od, sd);
                chk("stall_last", 32'(ol), 32'(sl));
            end
            chk("busy", 32'(bz), 32'd1);
            if (dn) begin
                got_done = 1;
                out_ready = 1'b0;
                chk("word_count", 32'(idx), 32'(exp.size()));
                if (mode == 0) chk("done_cycle", 32'(cyc), 32'(2 * exp.size() + 1));
            end else begin
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                if (ov) begin
                    chk("rd_addr", 32'(rr), 32'((idx > 31) ? 31 : idx));
                    if (out_ready) begin
                        if (idx < exp.size()) chk("word", od, exp[idx]);
                        else                  chk("extra_word", 32'(ov), 32'd0);
                        chk("last", 32'(ol), 32'(idx == exp.size() - 1));
                        idx++;
                    end
                end
                stall = ov && !out_ready;
                sd = od;
                sl = ol;
            end
        end
        if (!got_done) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk("done_width", 32'(dn), 32'd0);
        chk("idle_busy", 32'(bz), 32'd0);
        chk("idle_addr", 32'(rr), 32'd0);
        if (!hold) begin
            @(negedge clk);
            chk("no_queued_start", 32'(bz), 32'd0);
        end
    endtask

    task automatic write3(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wr3 = 1'b1; wa3 = a; wd3 = d;
        @(negedge clk);
        wr3 = 1'b0;
    endtask

    // One dump of the LAST_REG=3 instance; optionally writes reg2 during
    // the FETCH cycle of index 2.
    task automatic dump3(input bit inject, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e[5];
        int          n;
        int          idx;
        bit          got;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        e[4] = e0 ^ e1 ^ e2 ^ e3;
        n = CSUM ? 5 : 4;
        idx = 0; got = 0;
        @(negedge clk);
        start3 = 1'b1; ready3 = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            start3 = 1'b0;
            wr3 = 1'b0;
            if (dn3) begin
                got = 1;
            end else if (ov3) begin
                if (idx < n) chk("u3_word", od3, e[idx]);
                else         chk("u3_extra", 32'(ov3), 32'd0);
                chk("u3_last", 32'(ol3), 32'(idx == n - 1));
                idx++;
            end else if (inject && bz3 && rr3 == 5'd2 && idx == 2) begin
                wr3 = 1'b1; wa3 = 5'd2; wd3 = 32'hDEADBEEF;
            end
        end
        wr3 = 1'b0;
        chk("u3_count", 32'(idx), 32'(n));
        chk("u3_done", 32'(got), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        bit found;

        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11111111;

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(ov), 32'd0);
        chk("rst_data", od, 32'd0);
        chk("rst_last", 32'(ol), 32'd0);
        chk("rst_busy", 32'(bz), 32'd0);
        chk("rst_done", 32'(dn), 32'd0);
        chk("rst_addr", 32'(rr), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_start", 32'(bz), 32'd0);

        // full-rate dump of i*0x11111111
        @(negedge clk); start = 1'b1;
        collect(0, 0);

        // reg[i] = i: checksum word (if present) is XOR of 0..31 = 0
        for (int i = 0; i < 32; i++) regs[i] = 32'(i);
        @(negedge clk); start = 1'b1;
        collect(0, 0);

        // ready 1,0,0,1 pattern
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        @(negedge clk); start = 1'b1;
        collect(1, 0);

        // random ready with start noise while busy
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            @(negedge clk); start = 1'b1;
            collect(2, 0);
        end

        // reset while word 10 is in SEND
        @(negedge clk); start = 1'b1; out_ready = 1'b1;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (ov && rr == 5'd10) found = 1;
        end
        chk("abort_reached", 32'(found), 32'd1);
        rst = 1'b1; out_ready = 1'b0;
        #1;
        chk("abort_valid", 32'(ov), 32'd0);
        chk("abort_data", od, 32'd0);
        chk("abort_last", 32'(ol), 32'd0);
        chk("abort_busy", 32'(bz), 32'd0);
        chk("abort_done", 32'(dn), 32'd0);
        chk("abort_addr", 32'(rr), 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_abort_done", 32'(dn), 32'd0);
            chk("post_abort_busy", 32'(bz), 32'd0);
        end
        @(negedge clk); start = 1'b1;
        collect(0, 0);

        // start held high: one dump, then a fresh one from IDLE
        @(negedge clk); start = 1'b1;
        collect(0, 1);
        collect(0, 0);

        // write to reg2 during its FETCH cycle is not seen until the re-dump
        write3(5'd0, 32'h000000A0);
        write3(5'd1, 32'h000000A1);
        write3(5'd2, 32'h000000A2);
        write3(5'd3, 32'h000000A3);
        dump3(1'b1, 32'h000000A0, 32'h000000A1, 32'h000000A2, 32'h000000A3);
        dump3(1'b0, 32'h000000A0, 32'h000000A1, 32'hDEADBEEF, 32'h000000A3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
